btn_conditioner: RTL and testbench

Input-conditioning stage directly upstream of the game FSM. It takes the four raw paddle push-buttons (player A and player B, right and left) and turns each into a clean single-cycle move command on `btn_rh_a`, `btn_lf_a`, `btn_rh_b` and `btn_lf_b`. Each button is synchronised, debounced and edge-detected, with optional hold-to-repeat. The FSM sees at most one pulse per intended step and never a bounce or a metastable level.

---
 rtl/btn_conditioner.sv | 154 +++++++++++++++
 tb/tb_btn_conditioner.sv | 132 +++++++++++++
 2 files changed

// File: rtl/btn_conditioner.sv
// rtl/btn_conditioner.sv - sync, debounce and edge/repeat pulses for four paddle buttons
// Optional hold-to-repeat is enabled by defining BTN_AUTO_REPEAT_EN.
module btn_conditioner #(
    parameter int DEB_CYCLES    = 500000,
    parameter int REPEAT_DELAY  = 12500000,
    parameter int REPEAT_PERIOD = 1000000,
    parameter int CW            = 24,
    parameter bit ACTIVE_LOW_IN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] raw_btn,
    output logic       btn_rh_a,
    output logic       btn_lf_a,
    output logic       btn_rh_b,
    output logic       btn_lf_b,
    output logic [3:0] held
);

    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYCLES - 1);

`ifdef BTN_AUTO_REPEAT_EN
    typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} state_t;
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
    logic [CW-1:0] rc_q [4];
    logic [CW-1:0] rc_d [4];
`else
    typedef enum logic {ST_IDLE, ST_HOLD} state_t;
`endif

    logic [3:0]    norm;
    logic [3:0]    sync1_q, sync1_d;
    logic [3:0]    s_q, s_d;
    logic [3:0]    deb_q, deb_d;
    logic [3:0]    held_q, held_d;
    logic [3:0]    pulse_q, pulse_d;
    logic [3:0]    pressed;
    logic [3:0]    conflict;
    logic [CW-1:0] dc_q [4];
    logic [CW-1:0] dc_d [4];
    state_t        st_q [4];
    state_t        st_d [4];

    assign norm = ACTIVE_LOW_IN ? ~raw_btn : raw_btn;

    // Including the previous cycle keeps the survivor blocked until the released
    // button's held bit has actually dropped, so its delay starts from that edge.
    assign pressed  = deb_q | held_q;
    assign conflict = {{2{pressed[3] & pressed[2]}}, {2{pressed[1] & pressed[0]}}};

    always_comb begin
        sync1_d = norm;
        s_d     = sync1_q;
        held_d  = deb_q;
        deb_d   = deb_q;
        pulse_d = '0;
        for (int i = 0; i < 4; i++) begin
            dc_d[i] = '0;
            st_d[i] = st_q[i];
`ifdef BTN_AUTO_REPEAT_EN
            rc_d[i] = rc_q[i];
`endif
            if (s_q[i] != deb_q[i]) begin
                if (dc_q[i] == DEB_LAST) begin
                    deb_d[i] = s_q[i];
                end else begin
                    dc_d[i] = dc_q[i] + 1'b1;
                end
            end

`ifdef BTN_AUTO_REPEAT_EN
            if (!deb_q[i]) begin
                st_d[i] = ST_IDLE;
                rc_d[i] = '0;
            end else if (conflict[i]) begin
                st_d[i] = ST_DELAY;
                rc_d[i] = '0;
            end else begin
                case (st_q[i])
                    ST_IDLE: begin
                        pulse_d[i] = 1'b1;
                        st_d[i]    = ST_DELAY;
                        rc_d[i]    = '0;
                    end
                    ST_DELAY: begin
                        if (rc_q[i] == DLY_LAST) begin
                            pulse_d[i] = 1'b1;
                            rc_d[i]    = '0;
                            st_d[i]    = ST_REPEAT;
                        end else begin
                            rc_d[i] = rc_q[i] + 1'b1;
                        end
                    end
                    default: begin
                        if (rc_q[i] == PER_LAST) begin
                            pulse_d[i] = 1'b1;
                            rc_d[i]    = '0;
                        end else begin
                            rc_d[i] = rc_q[i] + 1'b1;
                        end
                    end
                endcase
            end
`else
            if (!deb_q[i]) begin
                st_d[i] = ST_IDLE;
            end else if (conflict[i]) begin
                st_d[i] = ST_HOLD;
            end else if (st_q[i] == ST_IDLE) begin
                pulse_d[i] = 1'b1;
                st_d[i]    = ST_HOLD;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_q <= '0;
            s_q     <= '0;
            deb_q   <= '0;
            held_q  <= '0;
            pulse_q <= '0;
            for (int i = 0; i < 4; i++) begin
                dc_q[i] <= '0;
                st_q[i] <= ST_IDLE;
`ifdef BTN_AUTO_REPEAT_EN
                rc_q[i] <= '0;
`endif
            end
        end else begin
            sync1_q <= sync1_d;
            s_q     <= s_d;
            deb_q   <= deb_d;
            held_q  <= held_d;
            pulse_q <= pulse_d;
            for (int i = 0; i < 4; i++) begin
                dc_q[i] <= dc_d[i];
                st_q[i] <= st_d[i];
`ifdef BTN_AUTO_REPEAT_EN
                rc_q[i] <= rc_d[i];
`endif
            end
        end
    end

    assign btn_rh_a = pulse_q[0];
    assign btn_lf_a = pulse_q[1];
    assign btn_rh_b = pulse_q[2];
    assign btn_lf_b = pulse_q[3];
    assign held     = held_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// tb/tb_btn_conditioner.sv - directed bench for btn_conditioner
module tb_btn_conditioner;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] raw_btn = 4'hF;
    logic       btn_rh_a, btn_lf_a, btn_rh_b, btn_lf_b;
    logic [3:0] held;

    int checks = 0;
    int errors = 0;

`ifdef BTN_AUTO_REPEAT_EN
    localparam bit REP = 1'b1;
`else
    localparam bit REP = 1'b0;
`endif

    btn_conditioner #(
        .DEB_CYCLES   (4),
        .REPEAT_DELAY (20),
        .REPEAT_PERIOD(8),
        .CW           (8),
        .ACTIVE_LOW_IN(1'b1)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .raw_btn (raw_btn),
        .btn_rh_a(btn_rh_a),
        .btn_lf_a(btn_lf_a),
        .btn_rh_b(btn_rh_b),
        .btn_lf_b(btn_lf_b),
        .held    (held)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int e, input logic [3:0] exp_pulse, input logic [3:0] exp_held);
        logic [7:0] obs, exp;
        obs = {held, btn_lf_b, btn_rh_b, btn_lf_a, btn_rh_a};
        exp = {exp_held, exp_pulse};
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed held/pulse=%b required=%b", tag, e, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] ep, eh;

        // reset state
        rst = 1'b0;
        raw_btn = 4'hF;
        tick();
        tick();
        check("reset", 0, 4'b0000, 4'b0000);
        rst = 1'b1;
        repeat (3) tick();
        check("idle", 0, 4'b0000, 4'b0000);

        // single press on rh_a, then release
        raw_btn = 4'b1110;
        for (int e = 0; e <= 12; e++) begin
            tick();
            check("press_rh_a", e, {3'b000, e == 6}, {3'b000, e >= 6});
        end
        raw_btn = 4'hF;
        for (int e = 0; e <= 10; e++) begin
            tick();
            check("release_rh_a", e, 4'b0000, {3'b000, e < 6});
        end
        repeat (4) tick();

        // bounce on lf_a: 3 low, 1 high, three times
        for (int e = 0; e < 18; e++) begin
            raw_btn = (e < 12 && (e % 4) != 3) ? 4'b1101 : 4'b1111;
            tick();
            check("bounce_lf_a", e, 4'b0000, 4'b0000);
        end
        repeat (4) tick();

        // long hold on rh_b
        raw_btn = 4'b1011;
        for (int e = 0; e < 60; e++) begin
            tick();
            ep = 4'b0000;
            ep[2] = (e == 6) || (REP && (e == 26 || e == 34 || e == 42 || e == 50 || e == 58));
            check("hold_rh_b", e, ep, {1'b0, e >= 6, 2'b00});
        end
        raw_btn = 4'hF;
        repeat (12) tick();
        check("after_rh_b", 0, 4'b0000, 4'b0000);

        // player A conflict, lf_a released 30 cycles later
        raw_btn = 4'b1100;
        for (int e = 0; e <= 62; e++) begin
            tick();
            ep = {3'b000, REP && e == 56};
            eh = {2'b00, e >= 6 && e < 36, e >= 6};
            check("conflict_a", e, ep, eh);
            if (e == 29) raw_btn = 4'b1110;
        end
        raw_btn = 4'hF;
        repeat (12) tick();
        check("after_conflict", 0, 4'b0000, 4'b0000);

        // hold lf_b through a mid-REPEAT reset
        raw_btn = 4'b0111;
        for (int e = 0; e <= 70; e++) begin
            tick();
            ep = 4'b0000;
            ep[3] = (e == 6) || (e == 45) || (REP && (e == 26 || e == 34 || e == 65));
            eh = {((e >= 6 && e <= 36) || e >= 45), 3'b000};
            check("reset_mid_lf_b", e, ep, eh);
            if (e == 36) rst = 1'b0;
            if (e == 38) rst = 1'b1;
        end
        raw_btn = 4'hF;
        repeat (12) tick();
        check("final_idle", 0, 4'b0000, 4'b0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
